// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the supported oversampling ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // Unsupported ratios fall back to 8 so the bit-period counter always wraps.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        return (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_8;
    endfunction

endpackage

// File: rtl/data_sampling.sv
// Three-point majority sampler: captures RX_IN around mid-bit and votes.
module data_sampling (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] edge_cnt,
    input  logic [5:0] Prescale,
    output logic       sampled_bit
);

    logic [5:0] mid;
    logic [2:0] samples;

    assign mid = Prescale >> 1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samples <= '0;
        end else begin
            if (edge_cnt == mid - 6'd1) samples[0] <= RX_IN;
            if (edge_cnt == mid)        samples[1] <= RX_IN;
            if (edge_cnt == mid + 6'd1) samples[2] <= RX_IN;
        end
    end

    // All three samples are registered well before edge_cnt reaches Prescale-1.
    assign sampled_bit = (samples[0] & samples[1]) |
                         (samples[0] & samples[2]) |
                         (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with one-cycle status pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_e   state;
    logic [5:0]    edge_cnt;
    logic [5:0]    prescale_r;
    logic [BW-1:0] bit_cnt;
    logic          par_en_r;
    logic          par_typ_r;
    logic          par_fail;
    logic          sampled_bit;
    logic          bit_end;

    assign bit_end = (edge_cnt == prescale_r - 6'd1);

    data_sampling u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .edge_cnt   (edge_cnt),
        .Prescale   (prescale_r),
        .sampled_bit(sampled_bit)
    );

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below reads the pre-edge values, regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
            par_fail   <= 1'b0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            prescale_r <= PRESCALE_8;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
            edge_cnt   <= bit_end ? 6'd0 : edge_cnt + 6'd1;

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    // The falling-edge cycle itself is edge 0 of the start bit.
                    if (!RX_IN) begin
                        state      <= START;
                        edge_cnt   <= 6'd1;
                        par_en_r   <= PAR_EN;
                        par_typ_r  <= PAR_TYP;
                        prescale_r <= legal_prescale(Prescale);
                        par_fail   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (sampled_bit) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        P_DATA  <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= par_en_r ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        if (sampled_bit != (^P_DATA ^ par_typ_r)) par_fail <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!sampled_bit)  Stop_Err   <= 1'b1;
                        else if (par_fail) Par_Err    <= 1'b1;
                        else               Data_Valid <= 1'b1;
                        // A low line here is already the next frame's start bit.
                        if (!RX_IN) begin
                            state      <= START;
                            edge_cnt   <= 6'd1;
                            par_en_r   <= PAR_EN;
                            par_typ_r  <= PAR_TYP;
                            prescale_r <= legal_prescale(Prescale);
                            par_fail   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built frames, pulse counting and latency measurement.
module tb_uart_rx;
    import uart_pkg::*;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stop_Err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start = 0;
    int dv_cnt, pe_cnt, se_cnt, dv_cyc;
    logic [7:0]  dv_data;
    uart_state_e se_state;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .Par_Err   (Par_Err),
        .Stop_Err  (Stop_Err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_cnt++;
            dv_cyc  = cyc;
            dv_data = P_DATA;
        end
        if (Par_Err) pe_cnt++;
        if (Stop_Err) begin
            se_cnt++;
            se_state = dut.state;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        dv_cnt = 0; pe_cnt = 0; se_cnt = 0; dv_cyc = 0; dv_data = '0;
    endtask

    // Drives one frame starting at a falling clock edge; disturb changes the
    // configuration inputs right after the start bit.
    task automatic send_frame(input logic [7:0] data, input int p, input logic pe,
                              input logic pt, input logic par_bit, input logic stop_bit,
                              input logic disturb);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        Prescale = 6'(p);
        clear_counts();
        @(negedge CLK);
        t_start = cyc;
        RX_IN   = 1'b0;
        repeat (p) @(negedge CLK);
        if (disturb) begin
            PAR_EN   = ~pe;
            PAR_TYP  = ~pt;
            Prescale = 6'd32;
        end
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            repeat (p) @(negedge CLK);
        end
        if (pe) begin
            RX_IN = par_bit;
            repeat (p) @(negedge CLK);
        end
        RX_IN = stop_bit;
        repeat (p) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (2 * p) @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        clear_counts();
        repeat (3) @(negedge CLK);
        check("rst_p_data", 32'(P_DATA), 32'h0);
        check("rst_dv", 32'(Data_Valid), 32'h0);
        check("rst_par_err", 32'(Par_Err), 32'h0);
        check("rst_stop_err", 32'(Stop_Err), 32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // 0xA5 has four ones: even parity bit is 0
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("p8_even_dv_cnt", 32'(dv_cnt), 32'd1);
        check("p8_even_latency", 32'(dv_cyc - t_start), 32'd88);
        check("p8_even_data", 32'(dv_data), 32'hA5);
        check("p8_even_errs", 32'(pe_cnt + se_cnt), 32'd0);
        check("p8_even_hold", 32'(P_DATA), 32'hA5);

        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("p16_nopar_dv_cnt", 32'(dv_cnt), 32'd1);
        check("p16_nopar_latency", 32'(dv_cyc - t_start), 32'd160);
        check("p16_nopar_data", 32'(dv_data), 32'h3C);
        check("p16_nopar_errs", 32'(pe_cnt + se_cnt), 32'd0);

        // Odd parity for 0xA5 needs parity bit 1; sending 0 is a parity error
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("odd_bad_par_err", 32'(pe_cnt), 32'd1);
        check("odd_bad_dv", 32'(dv_cnt), 32'd0);
        check("odd_bad_stop_err", 32'(se_cnt), 32'd0);

        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stop0_stop_err", 32'(se_cnt), 32'd1);
        check("stop0_dv", 32'(dv_cnt), 32'd0);
        check("stop0_par_err", 32'(pe_cnt), 32'd0);
        check("stop0_restart", 32'(se_state), 32'(START));
        check("stop0_settle_idle", 32'(dut.state), 32'(IDLE));

        // Bad parity and bad stop together: stop error wins
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("prio_stop_err", 32'(se_cnt), 32'd1);
        check("prio_par_err", 32'(pe_cnt), 32'd0);
        check("prio_dv", 32'(dv_cnt), 32'd0);

        // 0x01 odd parity: XOR=1, expected bit 1^1=0
        send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("p32_dv_cnt", 32'(dv_cnt), 32'd1);
        check("p32_latency", 32'(dv_cyc - t_start), 32'd352);
        check("p32_data", 32'(dv_data), 32'h01);

        // Configuration inputs change mid-frame; captured values must rule
        send_frame(8'h96, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("cfg_hold_dv_cnt", 32'(dv_cnt), 32'd1);
        check("cfg_hold_latency", 32'(dv_cyc - t_start), 32'd88);
        check("cfg_hold_data", 32'(dv_data), 32'h96);
        check("cfg_hold_errs", 32'(pe_cnt + se_cnt), 32'd0);

        // Two-cycle glitch is rejected
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        clear_counts();
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (24) @(negedge CLK);
        check("glitch_pulses", 32'(dv_cnt + pe_cnt + se_cnt), 32'd0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_p_data", 32'(P_DATA), 32'h96);

        // Reset during data bit 4, then a clean frame
        clear_counts();
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = 1'b1;
            repeat (8) @(negedge CLK);
        end
        RX_IN = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        check("midrst_p_data", 32'(P_DATA), 32'h0);
        RX_IN = 1'b1;
        RST   = 1'b0;
        repeat (24) @(negedge CLK);
        check("midrst_no_pulse", 32'(dv_cnt + pe_cnt + se_cnt), 32'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("after_rst_dv_cnt", 32'(dv_cnt), 32'd1);
        check("after_rst_latency", 32'(dv_cyc - t_start), 32'd80);
        check("after_rst_data", 32'(dv_data), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the number of data bits per frame.
REQ-002 SHALL have port CLK, input, 1 bit, the single clock, oversampling at Prescale times the bit rate.
REQ-003 SHALL have port RST, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port RX_IN, input, 1 bit, the serial line; idle level 1.
REQ-005 SHALL have port PAR_EN, input, 1 bit; 1 means the frame carries a parity bit.
REQ-006 SHALL have port PAR_TYP, input, 1 bit; 0 means even parity, 1 means odd parity.
REQ-007 SHALL have port Prescale, input, 6 bits, oversampling ratio; legal values are 8, 16 and 32.
REQ-008 SHALL have port P_DATA, output, DATA_WIDTH bits, the received word.
REQ-009 SHALL have port Data_Valid, output, 1 bit, a one-cycle pulse marking a good frame.
REQ-010 SHALL have ports Par_Err and Stop_Err, outputs, 1 bit each, one-cycle error pulses.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-012 SHALL keep edge_cnt running 0..Prescale-1 inside each bit period and wrapping to 0; bit_cnt SHALL count data bits.
REQ-013 SHALL, in IDLE, move to START on the first cycle RX_IN=0, with edge_cnt=0 in that cycle.
REQ-014 SHALL form each bit sample as the majority vote of RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-015 SHALL, at the end of START (edge_cnt=Prescale-1), return to IDLE if the sampled start bit is 1 (glitch reject) and otherwise go to DATA.
REQ-016 SHALL, in DATA, shift samples LSB-first into P_DATA; after DATA_WIDTH bits it SHALL go to PARITY if PAR_EN=1, otherwise to STOP.
REQ-017 SHALL, in PARITY, compare the sample with XOR(P_DATA) XOR PAR_TYP; on mismatch it SHALL set an internal par_fail flag.
REQ-018 SHALL, at the end of STOP, pulse exactly one of Data_Valid, Par_Err or Stop_Err for one cycle.
REQ-019 SHALL give Stop_Err priority over Par_Err when the stop sample is 0; Par_Err applies if par_fail is set; otherwise Data_Valid.
REQ-020 SHALL hold P_DATA stable from the Data_Valid pulse until the next frame's first data-bit shift.
REQ-021 SHALL, at the end of STOP, enter START directly if RX_IN=0 in that cycle (back-to-back frames) and otherwise enter IDLE.
REQ-022 SHALL capture PAR_EN, PAR_TYP and Prescale on entry to START; changes mid-frame SHALL have no effect until the next frame.
REQ-023 SHALL produce the Data_Valid pulse exactly (1+DATA_WIDTH+PAR_EN+1)*Prescale cycles after the START-entry cycle.

Reset
REQ-024 SHALL, while RST=1, force state=IDLE, edge_cnt=0, bit_cnt=0, P_DATA=0, Data_Valid=0, Par_Err=0, Stop_Err=0 and par_fail=0.
REQ-025 SHALL, when RST asserts mid-frame, abort the frame with no output pulse; after release it SHALL await a new falling edge.

Structure
REQ-026 SHALL place the FSM state encoding and legal prescale constants (8/16/32) in shared package uart_pkg, which is also used by the TX side.
REQ-027 SHALL put the three-point majority sampler in sub-module data_sampling (inputs RX_IN, edge_cnt, Prescale; output sampled_bit).

Verification
REQ-028 SHALL verify: Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> Data_Valid pulse 88 cycles after start, P_DATA=0xA5, no errors.
REQ-029 SHALL verify: Prescale=16, PAR_EN=0, frame 0x3C -> Data_Valid at cycle 160, P_DATA=0x3C.
REQ-030 SHALL verify: PAR_TYP=1, frame 0xA5 sent with parity 0 -> Par_Err pulse only, no Data_Valid.
REQ-031 SHALL verify: frame with stop bit 0 -> Stop_Err pulse only; the FSM re-enters START.
REQ-032 SHALL verify: RX_IN low for 2 cycles at Prescale=8, then high -> return to IDLE with no output pulses.
REQ-033 SHALL verify: RST pulse during DATA bit 4, then a clean 0x5A frame -> no pulse for the aborted frame, Data_Valid with 0x5A.
